// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: fetch PC, credit-limited imem requests, response FIFO and redirect flush.
// Optional FETCH_PERF_EN adds perf_redirects / perf_bubbles counters.
module instr_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_addr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_bubbles
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {FETCH, DRAIN} state_t;
  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]      out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [AW-1:0]      rd_q, rd_d, wr_q, wr_d;
  logic [63:0]        mem_q [DEPTH];
  logic [31:0]        target;
  logic               accept, push, pop;
  assign target         = {redirect_addr[31:2], 2'b00};
  assign imem_req_valid = reset & !redirect & ((CW+1)'(out_q) + (CW+1)'(cnt_q) < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign instr_valid    = cnt_q != '0;
  assign instr          = instr_valid ? mem_q[rd_q][63:32] : '0;
  assign instr_addr     = instr_valid ? mem_q[rd_q][31:0] : '0;
  assign accept         = imem_req_valid & imem_req_ready;
  assign push           = imem_resp_valid & (state_q == FETCH) & !redirect;
  assign pop            = instr_valid & !stall & !redirect;
  always_comb begin
    fetch_pc_d = redirect ? target : accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
    resp_pc_d  = redirect ? target : push ? resp_pc_q + 32'd4 : resp_pc_q;
    out_d      = out_q + CW'(accept) - CW'(imem_resp_valid);
    drop_d     = redirect ? out_d : (imem_resp_valid && state_q == DRAIN) ? drop_q - 1'b1 : drop_q;
    cnt_d      = redirect ? '0 : cnt_q + CW'(push) - CW'(pop);
    rd_d       = redirect ? '0 : rd_q + AW'(pop);
    wr_d       = redirect ? '0 : wr_q + AW'(push);
    state_d    = (drop_d != '0) ? DRAIN : FETCH;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= {imem_resp_data, resp_pc_q};
  end
`ifdef FETCH_PERF_EN
  logic [31:0] perf_red_q, perf_bub_q;
  assign perf_redirects = perf_red_q;
  assign perf_bubbles   = perf_bub_q;
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_red_q <= '0;
      perf_bub_q <= '0;
    end else begin
      perf_red_q <= perf_red_q + 32'(redirect);
      perf_bub_q <= perf_bub_q + 32'(!instr_valid);
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb_instr_fetch_buffer: random stimulus against a request/stream-level reference model.
module tb_instr_fetch_buffer;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic        clock = 1'b0, reset = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic        imem_req_ready = 1'b0, imem_resp_valid = 1'b0;
  logic [31:0] redirect_addr = '0, imem_resp_data = '0;
  logic        imem_req_valid, instr_valid;
  logic [31:0] imem_req_addr, instr, instr_addr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirects, perf_bubbles, m_red, m_bub;
`endif
  always #5 clock = ~clock;
  instr_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_addr(redirect_addr), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid), .instr(instr), .instr_addr(instr_addr)
`ifdef FETCH_PERF_EN
    , .perf_redirects(perf_redirects), .perf_bubbles(perf_bubbles)
`endif
  );
  typedef struct {logic [31:0] a; int c; bit stale;} req_t;
  typedef struct {logic [31:0] a; logic [31:0] d;} ent_t;
  req_t        pend[$];
  ent_t        fifo[$];
  logic [31:0] m_pc;
  int          cyc = 0, vectors = 0, miscompares = 0;
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic do_reset(input int n);
    reset = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    imem_resp_valid = 1'b0;
    pend.delete();
    fifo.delete();
    m_pc = RESET_PC;
    @(posedge clock); #1;
    repeat (n) begin
      @(negedge clock);
      chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
      chk("rst_instr_valid", 64'(instr_valid), 64'd0);
      chk("rst_instr", 64'(instr), 64'd0);
      chk("rst_instr_addr", 64'(instr_addr), 64'd0);
`ifdef FETCH_PERF_EN
      chk("rst_perf_red", 64'(perf_redirects), 64'd0);
      chk("rst_perf_bub", 64'(perf_bubbles), 64'd0);
      m_red = '0;
      m_bub = '0;
`endif
      @(posedge clock); #1;
    end
    reset = 1'b1;
  endtask
  task automatic step(input int p_stall, input int p_red, input int p_ready, input int p_resp);
    bit   exp_rv;
    req_t r;
    int   sel;
    stall = ($urandom % 100) < p_stall;
    redirect = ($urandom % 100) < p_red;
    sel = $urandom % 4;
    redirect_addr = sel == 0 ? 32'h0000_0100 : sel == 1 ? 32'h0000_0203 :
                    sel == 2 ? 32'hFFFF_FFF9 : $urandom;
    imem_req_ready = ($urandom % 100) < p_ready;
    imem_resp_valid = 1'b0;
    imem_resp_data = $urandom;
    if (pend.size() != 0 && pend[0].c < cyc && ($urandom % 100) < p_resp) begin
      imem_resp_valid = 1'b1;
      imem_resp_data = word_at(pend[0].a);
    end
    @(negedge clock);
    exp_rv = !redirect && (pend.size() + fifo.size() < DEPTH);
    chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
    if (exp_rv) chk("req_addr", 64'(imem_req_addr), 64'(m_pc));
    chk("instr_valid", 64'(instr_valid), 64'(fifo.size() != 0));
    if (fifo.size() != 0) begin
      chk("instr", 64'(instr), 64'(fifo[0].d));
      chk("instr_addr", 64'(instr_addr), 64'(fifo[0].a));
    end
`ifdef FETCH_PERF_EN
    chk("perf_redirects", 64'(perf_redirects), 64'(m_red));
    chk("perf_bubbles", 64'(perf_bubbles), 64'(m_bub));
    m_red += 32'(redirect);
    m_bub += 32'(fifo.size() == 0);
`endif
    if (fifo.size() != 0 && !stall && !redirect) void'(fifo.pop_front());
    if (imem_resp_valid) begin
      r = pend.pop_front();
      if (!r.stale && !redirect) fifo.push_back('{r.a, word_at(r.a)});
    end
    if (exp_rv && imem_req_ready) begin
      pend.push_back('{m_pc, cyc, 1'b0});
      m_pc += 32'd4;
    end
    if (redirect) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      fifo.delete();
      m_pc = redirect_addr & ~32'd3;
    end
    cyc++;
    @(posedge clock); #1;
  endtask
  initial begin
    do_reset(3);
    repeat (20) step(0, 0, 100, 100);
    repeat (10) step(100, 0, 100, 100);
    repeat (20) step(0, 0, 100, 100);
    repeat (5) step(0, 0, 0, 100);
    repeat (30) step(20, 10, 100, 100);
    repeat (2000) step(30, 5, 70, 60);
    repeat (500) step(60, 15, 50, 40);
    do_reset(2);
    repeat (20) step(0, 0, 100, 100);
    repeat (1000) step(25, 4, 80, 70);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instr_fetch_buffer.md
Name: instr_fetch_buffer

Overview:
- Front-end fetch unit and the receiving end of the execute-stage redirect interface (jump / jump target).
- Owns the fetch PC and issues in-order instruction-memory read requests over a valid/ready handshake.
- Buffers returned instruction words in a small FIFO and presents them to decode with a stall backpressure.
- On redirect, flushes buffered words, discards in-flight responses and restarts fetch at the target.

Parameters:
- DEPTH, 4: FIFO entries; also the cap on (outstanding requests + buffered words). Power of two, ≥2.
- RESET_PC, 32'h0000_0000: fetch PC after reset.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  decode not accepting this cycle.
- redirect  in  1  execute stage took jal/jalr/branch.
- redirect_addr  in  32 (word)  new fetch target; bits[1:0] ignored and treated as 0.
- imem_req_valid  out  1  request pending.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned request address.
- imem_resp_valid  in  1  response word returned; strictly in request order, ≥1 cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- instr_valid  out  1  instr/instr_addr valid.
- instr  out  32  head-of-FIFO instruction.
- instr_addr  out  32  PC of that instruction.

Behaviour:
- Reset (reset==0 at edge):
  - fetch_pc=RESET_PC.
  - FIFO empty; outstanding=0; drop_count=0.
  - Outputs after reset: imem_req_valid=0, instr_valid=0, instr=0, instr_addr=0.
  - Reset mid-operation abandons all in-flight requests. Responses arriving later are ignored only if drop_count covers them, so the memory model must also be reset.
- Credit rule: imem_req_valid = reset_n & (outstanding + occupancy < DEPTH) & !redirect.
- imem_req_addr=fetch_pc, combinational from the register.
- Accept: imem_req_valid & imem_req_ready → fetch_pc += 4 (wraps mod 2^32), outstanding++.
  - A request held with valid=1 and ready=0 must keep a stable address.
- Response: imem_resp_valid → outstanding--.
  - If drop_count>0: drop_count--, word discarded.
  - Else: push {data, pc-tag}. The pc-tag comes from a separate resp_pc register that starts at the redirect/reset address and increments by 4 per pushed word.
- Pop: instr_valid & !stall removes the head. instr_valid = occupancy != 0.
- Simultaneous push and pop on a full FIFO is legal: occupancy unchanged. The credit rule guarantees a push never overflows.
- Redirect (highest priority, overrides stall):
  - fetch_pc=redirect_addr & ~3; resp_pc=same.
  - FIFO cleared; instr_valid=0 next cycle.
  - drop_count = outstanding after this cycle's accept/response accounting, so any response arriving in the redirect cycle is dropped.
  - No request is issued in the redirect cycle.
  - First new request is issued the cycle after.
- FSM (2 states):
  - FETCH: drop_count==0.
  - DRAIN: drop_count>0.
  - FETCH→DRAIN on redirect with outstanding>0.
  - DRAIN→FETCH when the last stale response is consumed.
  - Redirect in DRAIN reloads drop_count with the total outstanding (stale + new).
  - New requests may issue in DRAIN; credits still apply.
- Latency:
  - Redirect → imem_req_valid for target: 1 cycle.
  - Response → instr_valid: 1 cycle (registered FIFO).

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_redirects (32) and perf_bubbles (32), both reset to 0 and wrapping.
  - perf_redirects increments once per redirect cycle.
  - perf_bubbles increments each cycle with instr_valid==0 && reset==1.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, imem ready always, 1-cycle response latency → requests to 0x0,0x4,0x8…; instr_valid from cycle 3; instr_addr sequence 0x0,0x4,0x8 with matching data.
- stall held high 10 cycles, DEPTH=4 → at most 4 words buffered plus 0 outstanding; imem_req_valid drops to 0; release stall → words drain in order with no loss or duplication.
- Redirect to 0x100 with 2 requests outstanding → both stale responses dropped (state DRAIN for 2 responses); next instr_addr=0x100, then 0x104.
- Redirect and imem_resp_valid in the same cycle, plus stall=1 → the response is dropped, FIFO is emptied, and the first new request addresses the target.
- imem_req_ready=0 for 5 cycles → imem_req_addr stable, fetch_pc does not advance; redirect_addr=0x203 fetches from 0x200.
- FETCH_PERF_EN: 3 redirects and a 4-cycle empty window → perf_redirects=3, perf_bubbles ≥4 with exact count matched against the model.
